alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_seq_if.sv | 27 ++
 rtl/alu_mul_seq.sv | 94 +++++++++
 tb/tb_alu_mul_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_if.sv
// Command/result and slice-chain bus between the multiply sequencer and its neighbours.
// All multi-bit fields are big-endian: index 0 is the MSB.
interface alu_mul_seq_if #(parameter int W = 36);
  logic           start;
  logic [0:W-1]   mcand;
  logic [0:W-1]   mplier;
  logic           busy;
  logic           done;
  logic [0:2*W-1] prod;
  logic [0:3]     alu_s;
  logic           alu_m;
  logic           alu_cin;
  logic [0:W-1]   alu_a;
  logic [0:W-1]   alu_b;
  logic [0:W-1]   alu_f;
  logic           alu_cout;

  modport slave (
    input  start, mcand, mplier, alu_f, alu_cout,
    output busy, done, prod, alu_s, alu_m, alu_cin, alu_a, alu_b
  );

  modport master (
    output start, mcand, mplier, alu_f, alu_cout,
    input  busy, done, prod, alu_s, alu_m, alu_cin, alu_a, alu_b
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer; the external mc10181 slice chain does all adding.
// state | meaning
// IDLE  | waiting for start; prod holds the last result
// RUN   | one multiplier bit per cycle, W cycles, accumulating through the slice chain
// DONE  | prod valid, done pulses for one cycle
module alu_mul_seq #(
  parameter int W = 36
) (
  input  logic       clk,
  input  logic       reset,
  alu_mul_seq_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [0:W-1]    acc_q, mq_q, md_q;
  logic [CW-1:0]   cnt_q;
  logic [0:2*W-1]  prod_q;
  logic [0:2*W-1]  shifted;
  logic            last_step;

  // Carry-out enters at the top, so the 2W+1-bit sum shifts right into {acc,mq}.
  assign shifted   = {bus.alu_cout, bus.alu_f, mq_q[0:W-2]};
  assign last_step = (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.alu_s = 4'b0000;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (mq_q[W-1]) bus.alu_s = 4'b0110;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      mq_q   <= '0;
      md_q   <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            md_q  <= bus.mcand;
            mq_q  <= bus.mplier;
            acc_q <= '0;
            cnt_q <= CW'(W);
          end
        end
        RUN: begin
          acc_q <= shifted[0:W-1];
          mq_q  <= shifted[W:2*W-1];
          cnt_q <= cnt_q - CW'(1);
          // Capture on the final step so prod is already valid alongside done.
          if (last_step) prod_q <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign bus.prod    = prod_q;
  assign bus.alu_a   = acc_q;
  assign bus.alu_b   = md_q;
  assign bus.alu_m   = 1'b0;
  assign bus.alu_cin = 1'b0;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural 9-slice mc10181 chain, directed vectors and a
// scoreboard queue checked by a monitor on every done pulse.
module tb_alu_mul_seq;
  localparam int W = 36;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_mul_seq_if #(.W(W)) bus ();

  alu_mul_seq #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Ripple chain of 4-bit mc10181 slices, slice 0 least significant.
  // Only the arithmetic modes the sequencer uses are modelled; others give X.
  logic [0:W-1] f_chain;
  logic         cout_chain;
  logic [3:0]   a4, b4;
  logic [4:0]   sum;
  logic         c;

  always_comb begin
    f_chain    = '0;
    cout_chain = 1'b0;
    a4         = '0;
    b4         = '0;
    sum        = '0;
    c          = bus.alu_cin;
    for (int i = 0; i < W / 4; i++) begin
      a4 = bus.alu_a[W-4-4*i +: 4];
      b4 = bus.alu_b[W-4-4*i +: 4];
      case ({bus.alu_m, bus.alu_s})
        5'b00110: sum = {1'b0, a4} + {1'b0, b4} + {4'b0, c};
        5'b00000: sum = {1'b0, a4} + {4'b0, c};
        default:  sum = 'x;
      endcase
      f_chain[W-4-4*i +: 4] = sum[3:0];
      c = sum[4];
    end
    cout_chain = c;
  end

  assign bus.alu_f    = f_chain;
  assign bus.alu_cout = cout_chain;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_done = 0;
  logic [0:2*W-1] sb[$];
  logic [0:2*W-1] mon_exp;

  task automatic chk(input string name, input logic [0:2*W-1] act, input logic [0:2*W-1] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done++;
      chk_i("done_has_expected", (sb.size() != 0) ? 1 : 0, 1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("prod", bus.prod, mon_exp);
      end
    end
  end

  int         busy_n;
  int         done_cyc;
  int         s_add_n;
  bit         cout_seen;
  logic [0:3] s_hist[1:W];

  // Called just after a rising edge with the DUT idle; returns just after the edge leaving DONE.
  task automatic run(input logic [0:W-1] a, input logic [0:W-1] b, input bit hammer);
    bus.mcand  = a;
    bus.mplier = b;
    bus.start  = 1'b1;
    sb.push_back((2*W)'(a) * (2*W)'(b));
    n_acc++;
    busy_n    = 0;
    done_cyc  = 0;
    s_add_n   = 0;
    cout_seen = 1'b0;
    @(posedge clk); #1;
    if (!hammer) bus.start = 1'b0;
    for (int k = 1; k <= W + 4; k++) begin
      if (hammer) begin
        bus.mcand  = W'({$urandom, $urandom});
        bus.mplier = W'({$urandom, $urandom});
      end
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (k <= W) begin
        s_hist[k] = bus.alu_s;
        if (bus.alu_s != 4'b0000) s_add_n++;
        if (bus.alu_s == 4'b0110 && bus.alu_cout) cout_seen = 1'b1;
      end
      if (bus.done) begin
        done_cyc = k;
        break;
      end
    end
    bus.start = 1'b0;
    if (done_cyc == 0) chk_i("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [0:W-1] ra, rb;

  initial begin
    bus.start  = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("rst_busy", int'(bus.busy), 0);
    chk_i("rst_done", int'(bus.done), 0);
    chk("rst_prod", bus.prod, '0);
    chk_i("rst_alu_s", int'(bus.alu_s), 0);
    chk_i("rst_alu_m", int'(bus.alu_m), 0);
    chk_i("rst_alu_cin", int'(bus.alu_cin), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run(36'd3, 36'd5, 1'b0);
    chk_i("busy_len_3x5", busy_n, W + 1);
    chk_i("done_cycle_3x5", done_cyc, W + 1);
    chk_i("alu_s_c1", int'(s_hist[1]), 6);
    chk_i("alu_s_c2", int'(s_hist[2]), 0);
    chk_i("alu_s_c3", int'(s_hist[3]), 6);

    run(36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b0);
    chk_i("cout_seen_ones", int'(cout_seen), 1);

    run(36'h123456789, 36'd0, 1'b0);
    chk_i("alu_s_zero_mplier", s_add_n, 0);

    run(36'h123456789, 36'd1, 1'b0);
    chk_i("alu_s_one_mplier", s_add_n, 1);

    // start held high with changing operands for the whole run
    run(36'd11, 36'd13, 1'b1);
    chk_i("done_cycle_hammer", done_cyc, W + 1);
    repeat (2 * W) @(posedge clk);
    #1;
    chk_i("no_extra_done", n_done, n_acc);

    // reset during RUN cycle 10 discards the partial product
    bus.mcand  = 36'd100;
    bus.mplier = 36'd200;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_i("mid_rst_busy", int'(bus.busy), 0);
    chk_i("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_prod", bus.prod, '0);
    @(posedge clk); #1;

    run(36'd7, 36'd6, 1'b0);
    chk_i("done_cycle_7x6", done_cyc, W + 1);

    for (int r = 0; r < 1000; r++) begin
      ra = W'({$urandom, $urandom});
      rb = W'({$urandom, $urandom});
      run(ra, rb, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk_i("done_count", n_done, n_acc);
    chk_i("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
